day_calendar_counter: RTL
=========================

Name: day_calendar_counter

Overview:
- Sequential date source that produces the 5-bit "today" value consumed by the combinational yesterday / day-before-yesterday stage.
- Advances day (1..30), month (1..12) and year on a one-cycle day_tick pulse. Every month is 30 days.
- Supports a validated date load and a start from the reset date.
- Emits month and year rollover strobes for downstream logic.

Parameters:
DAYS_PER_MONTH, 30, last valid day value; legal range 2..31; tod stays 5 bits.
MONTHS_PER_YEAR, 12, last valid month value; legal range 2..15; mon stays 4 bits.
YEAR_W, 12, width of the year counter.
YEAR_RESET, 2000, year value loaded on reset; must fit in YEAR_W bits.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  pulse; enters RUN keeping the current (reset) date.
day_tick  input  1  one-cycle pulse; advance one day when in RUN.
hold  input  1  level; while high, day_tick is ignored (date frozen).
load_valid  input  1  request to load ld_day / ld_mon / ld_year.
ld_day  input  5  day to load, 1..DAYS_PER_MONTH.
ld_mon  input  4  month to load, 1..MONTHS_PER_YEAR.
ld_year  input  YEAR_W  year to load, any value.
tod  output  5  current day, registered; feeds the yesterday stage.
mon  output  4  current month, registered.
year  output  YEAR_W  current year, registered.
tod_valid  output  1  high in RUN; low in UNSET.
month_wrap  output  1  one-cycle pulse when the day rolls from DAYS_PER_MONTH to 1.
year_wrap  output  1  one-cycle pulse when the month rolls from MONTHS_PER_YEAR to 1.
load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - tod=1, mon=1, year=YEAR_RESET.
  - tod_valid=0; month_wrap, year_wrap and load_err = 0.
  - State = UNSET.
  - Reset mid-operation discards the date and any pending pulse immediately.
- FSM states: UNSET and RUN.
  - UNSET -> RUN on start, or on an accepted load.
  - RUN has no exit except reset.
  - start while in RUN has no effect.
- tod_valid is the registered state bit: 1 in RUN.
- Accepted load: load_valid=1, 1<=ld_day<=DAYS_PER_MONTH and 1<=ld_mon<=MONTHS_PER_YEAR.
  - Fields are registered at that edge; the new date is visible the next cycle.
  - An accepted load is allowed in either state and ignores hold.
- Rejected load: any field out of range (0 or above the maximum).
  - Date and state are unchanged.
  - load_err=1 for exactly the following cycle.
- Day advance: in RUN with day_tick=1, hold=0 and no load_valid.
  - tod = tod+1, or 1 if tod==DAYS_PER_MONTH.
  - On day rollover: mon = mon+1, or 1 if mon==MONTHS_PER_YEAR.
  - On month rollover: year = year+1, wrapping modulo 2^YEAR_W (all ones -> 0).
  - Latency: the tick at edge n is visible on outputs after edge n; pulses are high for the cycle after edge n.
- month_wrap and year_wrap are registered and assert together with the updated date. year_wrap is always accompanied by month_wrap.
- Simultaneous events:
  - load_valid together with day_tick: the load has priority and the tick is dropped. A rejected load also drops the tick.
  - start together with a valid load: enter RUN with the loaded date.
- In UNSET, day_tick is ignored and no wrap pulses are produced.
- Back-to-back ticks on consecutive cycles each advance one day.
- Out-of-range state is unreachable. If tod or mon is ever out of range, the next tick forces it to 1.

Test Plan:
- Reset, then day_tick x3 with no start -> tod=1, mon=1, year=2000, tod_valid=0, no pulses.
- start, then 29 ticks -> tod=30, mon=1. One more tick -> tod=1, mon=2, month_wrap=1 for one cycle, year_wrap=0.
- Load 30/12/2000, then a tick -> tod=1, mon=1, year=2001, month_wrap=1 and year_wrap=1 in the same cycle. With YEAR_W=12, loading year 4095 and rolling over gives year=0.
- load_valid with ld_day=0, then ld_day=31, then ld_mon=13 -> each gives load_err pulse 1 cycle later; date unchanged; state stays UNSET if not yet started.
- Same cycle: load 15/6/2010 plus day_tick -> tod=15, mon=6, year=2010 (tick dropped). hold=1 with 5 ticks -> date unchanged.
- Assert rst_n low mid-run at 20/7 with day_tick high -> outputs immediately 1/1/2000, tod_valid=0, no pulses after release.

Source files
------------

// File: rtl/day_calendar_counter.sv
// Day/month/year calendar driven by a one-cycle day tick, with validated date
// loading and registered month/year rollover strobes.
module day_calendar_counter #(
  parameter int DAYS_PER_MONTH  = 30,
  parameter int MONTHS_PER_YEAR = 12,
  parameter int YEAR_W          = 12,
  parameter int YEAR_RESET      = 2000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              day_tick,
  input  logic              hold,
  input  logic              load_valid,
  input  logic [4:0]        ld_day,
  input  logic [3:0]        ld_mon,
  input  logic [YEAR_W-1:0] ld_year,
  output logic [4:0]        tod,
  output logic [3:0]        mon,
  output logic [YEAR_W-1:0] year,
  output logic              tod_valid,
  output logic              month_wrap,
  output logic              year_wrap,
  output logic              load_err
);

  typedef enum logic {UNSET = 1'b0, RUN = 1'b1} state_e;

  localparam logic [4:0]        LAST_DAY  = 5'(DAYS_PER_MONTH);
  localparam logic [3:0]        LAST_MON  = 4'(MONTHS_PER_YEAR);
  localparam logic [YEAR_W-1:0] YEAR_INIT = YEAR_W'(YEAR_RESET);

  state_e            state_q, state_d;
  logic [4:0]        tod_q, tod_d;
  logic [3:0]        mon_q, mon_d;
  logic [YEAR_W-1:0] year_q, year_d;
  logic              month_wrap_q, month_wrap_d;
  logic              year_wrap_q, year_wrap_d;
  logic              load_err_q, load_err_d;
  logic              load_ok;
  logic              mon_bad;

  always_comb begin
    state_d      = state_q;
    tod_d        = tod_q;
    mon_d        = mon_q;
    year_d       = year_q;
    month_wrap_d = 1'b0;
    year_wrap_d  = 1'b0;
    load_err_d   = 1'b0;
    load_ok      = (ld_day != 5'd0) && (ld_day <= LAST_DAY) &&
                   (ld_mon != 4'd0) && (ld_mon <= LAST_MON);
    mon_bad      = (mon_q == 4'd0) || (mon_q > LAST_MON);

    if (load_valid) begin
      // Any load request, good or bad, swallows a coincident tick and start.
      if (load_ok) begin
        tod_d   = ld_day;
        mon_d   = ld_mon;
        year_d  = ld_year;
        state_d = RUN;
      end else begin
        load_err_d = 1'b1;
      end
    end else begin
      if (start) state_d = RUN;
      if (state_q == RUN && day_tick && !hold) begin
        if (mon_bad) mon_d = 4'd1;
        if (tod_q == LAST_DAY) begin
          tod_d        = 5'd1;
          month_wrap_d = 1'b1;
          if (mon_q == LAST_MON) begin
            mon_d       = 4'd1;
            year_d      = year_q + YEAR_W'(1);
            year_wrap_d = 1'b1;
          end else if (!mon_bad) begin
            mon_d = mon_q + 4'd1;
          end
        end else if (tod_q == 5'd0 || tod_q > LAST_DAY) begin
          tod_d = 5'd1;
        end else begin
          tod_d = tod_q + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= UNSET;
      tod_q        <= 5'd1;
      mon_q        <= 4'd1;
      year_q       <= YEAR_INIT;
      month_wrap_q <= 1'b0;
      year_wrap_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tod_q        <= tod_d;
      mon_q        <= mon_d;
      year_q       <= year_d;
      month_wrap_q <= month_wrap_d;
      year_wrap_q  <= year_wrap_d;
      load_err_q   <= load_err_d;
    end
  end

  assign tod        = tod_q;
  assign mon        = mon_q;
  assign year       = year_q;
  assign tod_valid  = (state_q == RUN);
  assign month_wrap = month_wrap_q;
  assign year_wrap  = year_wrap_q;
  assign load_err   = load_err_q;

endmodule
